serial_alu: RTL and testbench
=============================

# serial_alu

Multi-cycle, chunk-serial ALU core: the parametrised successor to the CPU's 8-bit nybble adder. It processes operands CHUNK bits per clock, least-significant chunk first, and carries between chunks in a register rather than through a combinational chain. It supports add, add-with-carry, subtract, subtract-with-borrow and compare at any WIDTH, and computes the Z/N/H/C flags. It sits in the CPU execute stage and serves both the 8-bit accumulator ops (WIDTH=8) and the 16-bit register-pair adds (WIDTH=16, HC_BIT=11).

## Interface
- WIDTH, 8: operand/result width; must be a multiple of CHUNK.
- CHUNK, 4: bits processed per cycle.
- HC_BIT, 3: H flag is the carry/borrow out of this bit; (HC_BIT+1) must be a multiple of CHUNK and less than WIDTH.
- i_Clk  in  1  clock, rising-edge.
- i_Reset_n  in  1  asynchronous, active-low reset.
- i_Start  in  1  request; sampled only when not busy.
- i_Op  in  3  000 ADD, 001 ADC, 010 SUB, 011 SBC, 100 CP; 101–111 behave as ADD.
- i_A  in  WIDTH  first operand.
- i_B  in  WIDTH  second operand.
- i_Carry  in  1  incoming C flag; used by ADC/SBC only.
- o_Busy  out  1  operation in progress.
- o_Done  out  1  one-cycle completion pulse.
- o_Result  out  WIDTH  result; held until the next completion.
- o_Z, o_N, o_H, o_C  out  1 each  flags; held until the next completion.

## Operation
- States:
  - IDLE: waiting for a request.
  - RUN: processing chunks 0 to NCH-1, where NCH = WIDTH/CHUNK.
  - IDLE again at completion (o_Done pulses).
- IDLE to RUN on i_Start=1. On that edge, latch A, B, op and carry-in, and clear the chunk counter.
  - Add ops: B' = B, cin = (ADC ? i_Carry : 0).
  - Sub ops (SUB/SBC/CP): B' = ~B, cin = ~(SBC ? i_Carry : 0).
- Each RUN cycle: {c, s} = A_chunk + B'_chunk + carry_reg. Store s into the result shift register and set carry_reg = c.
  - When the chunk ends at bit HC_BIT, capture c as the raw half-carry.
- After the last chunk:
  - C = final carry for add ops; C = ~final carry (borrow) for sub ops.
  - H = raw half-carry for add ops; H = ~raw half-carry for sub ops.
  - N = 1 for SUB/SBC/CP, 0 otherwise.
  - Z = 1 iff the computed WIDTH-bit sum is zero. For CP, this is the difference A−B.
  - o_Result = sum, except CP, where o_Result = latched A.
- Arithmetic is modulo 2^WIDTH; overflow beyond WIDTH appears only in C.
- i_Start while busy: ignored, no queueing. Operand inputs may change freely after the start edge.
- o_Result and all flags update only on the completion edge. They are stable at all other times.

## Timing
- Reset: asynchronous. Forces state IDLE; o_Busy, o_Done, o_Result, o_Z, o_N, o_H, o_C all 0; internal carry and counter cleared.
- Reset mid-operation: the operation is aborted, no o_Done is produced, and outputs are the reset values.
- Start accepted at edge t:
  - o_Busy = 1 after edge t.
  - Chunks are processed at edges t+1 through t+NCH.
  - At edge t+NCH: o_Busy drops to 0, o_Done rises, results are valid.
  - Latency is NCH cycles: 2 for WIDTH=8, 4 for WIDTH=16.
- o_Done is high for exactly one cycle.
- i_Start=1 during the o_Done cycle is accepted (back-to-back). Throughput is one op per NCH cycles.
- Degenerate case CHUNK=WIDTH: single-cycle RUN, and H = C source.

## Test plan
- WIDTH=8, ADD 0x3A + 0xC6 → o_Result=0x00, Z=1, N=0, H=1, C=1; o_Done exactly 2 cycles after the start edge, one-cycle wide.
- SUB 0x3E − 0x0F → 0x2F, Z=0, N=1, H=1, C=0. Then SBC 0x00 − 0x00 with i_Carry=1 → 0xFF, N=1, H=1, C=1.
- CP A=0x3C, B=0x40 → o_Result=0x3C, Z=0, N=1, H=0, C=1. CP 0x42 vs 0x42 → Z=1, C=0, H=0.
- WIDTH=16, HC_BIT=11: ADD 0x0FFF + 0x0001 → 0x1000, H=1, C=0; ADC 0xFFFF + 0x0000 with i_Carry=1 → 0x0000, Z=1, H=1, C=1; latency 4 cycles.
- Back-to-back and busy behaviour:
  - Pulse i_Start every cycle with changing operands: only starts in IDLE or on the o_Done cycle are taken.
  - Each result matches the operands present at its accepted start edge.
  - Outputs are unchanged between completions.
- Assert i_Reset_n=0 one cycle into RUN → all outputs 0 immediately (asynchronous); no o_Done afterwards. A new start after reset release completes normally.

Source files
------------

// File: rtl/serial_alu.sv
// serial_alu: chunk-serial add/sub/compare core. Operands are consumed
// CHUNK bits per clock, LS chunk first, with the inter-chunk carry held in
// a register. Result and Z/N/H/C flags publish together on the done edge.
module serial_alu #(
  parameter int WIDTH  = 8,
  parameter int CHUNK  = 4,
  parameter int HC_BIT = 3
) (
  input  logic             i_Clk,
  input  logic             i_Reset_n,
  input  logic             i_Start,
  input  logic [2:0]       i_Op,
  input  logic [WIDTH-1:0] i_A,
  input  logic [WIDTH-1:0] i_B,
  input  logic             i_Carry,
  output logic             o_Busy,
  output logic             o_Done,
  output logic [WIDTH-1:0] o_Result,
  output logic             o_Z,
  output logic             o_N,
  output logic             o_H,
  output logic             o_C
);

  localparam int NCH      = WIDTH / CHUNK;
  localparam int CW       = (NCH > 1) ? $clog2(NCH) : 1;
  // Chunk whose top bit is HC_BIT; when no chunk qualifies (CHUNK == WIDTH)
  // the half-carry falls back to the final carry.
  localparam int HC_IDX_R = (HC_BIT + 1) / CHUNK - 1;
  localparam int HC_IDX   = (HC_IDX_R < 0 || HC_IDX_R > NCH - 1) ? NCH - 1 : HC_IDX_R;
  localparam logic [CW-1:0] LAST_CNT = CW'(NCH - 1);
  localparam logic [CW-1:0] HC_CNT   = CW'(HC_IDX);

  localparam logic [2:0] OP_ADC = 3'd1;
  localparam logic [2:0] OP_SUB = 3'd2;
  localparam logic [2:0] OP_SBC = 3'd3;
  localparam logic [2:0] OP_CP  = 3'd4;

  typedef enum logic {IDLE, RUN} state_t;
  state_t state, state_nx;

  logic [WIDTH-1:0] a_sh, b_sh, a_keep, sum_sh;
  logic [CW-1:0]    cnt;
  logic             carry, hc_raw, is_sub, is_cp;

  logic             op_sub, op_cin;
  logic [WIDTH-1:0] b_in;
  logic [CHUNK:0]   csum;
  logic [WIDTH+CHUNK-1:0] sum_cat;
  logic [WIDTH-1:0] sum_new;
  logic             last, h_src;

  // Request decode: subtraction is A + ~B + ~borrow_in.
  always_comb begin
    op_sub = (i_Op == OP_SUB) || (i_Op == OP_SBC) || (i_Op == OP_CP);
    op_cin = op_sub ? ~((i_Op == OP_SBC) & i_Carry) : ((i_Op == OP_ADC) & i_Carry);
    b_in   = op_sub ? ~i_B : i_B;
  end

  // One chunk of the adder plus the result shift-in (new chunk enters at the top).
  always_comb begin
    csum    = {1'b0, a_sh[CHUNK-1:0]} + {1'b0, b_sh[CHUNK-1:0]} + {{CHUNK{1'b0}}, carry};
    sum_cat = {csum[CHUNK-1:0], sum_sh};
    sum_new = sum_cat[WIDTH+CHUNK-1:CHUNK];
    last    = (cnt == LAST_CNT);
    h_src   = (cnt == HC_CNT) ? csum[CHUNK] : hc_raw;
  end

  // State register.
  always_ff @(posedge i_Clk or negedge i_Reset_n) begin
    if (!i_Reset_n) state <= IDLE;
    else            state <= state_nx;
  end

  // Next state: starts are only seen in IDLE, so a start during the done
  // cycle is taken naturally and starts while running are dropped.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (i_Start) state_nx = RUN;
      RUN:     if (last)    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign o_Busy = (state == RUN);

  // Datapath: latch on start, shift one chunk per RUN cycle, publish on last.
  always_ff @(posedge i_Clk or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      a_sh     <= '0;
      b_sh     <= '0;
      a_keep   <= '0;
      sum_sh   <= '0;
      cnt      <= '0;
      carry    <= 1'b0;
      hc_raw   <= 1'b0;
      is_sub   <= 1'b0;
      is_cp    <= 1'b0;
      o_Done   <= 1'b0;
      o_Result <= '0;
      o_Z      <= 1'b0;
      o_N      <= 1'b0;
      o_H      <= 1'b0;
      o_C      <= 1'b0;
    end else begin
      o_Done <= 1'b0;
      if (state == IDLE) begin
        if (i_Start) begin
          a_sh   <= i_A;
          a_keep <= i_A;
          b_sh   <= b_in;
          carry  <= op_cin;
          is_sub <= op_sub;
          is_cp  <= (i_Op == OP_CP);
          cnt    <= '0;
          hc_raw <= 1'b0;
        end
      end else begin
        a_sh   <= a_sh >> CHUNK;
        b_sh   <= b_sh >> CHUNK;
        sum_sh <= sum_new;
        carry  <= csum[CHUNK];
        cnt    <= cnt + 1'b1;
        if (cnt == HC_CNT) hc_raw <= csum[CHUNK];
        if (last) begin
          o_Done   <= 1'b1;
          o_Result <= is_cp ? a_keep : sum_new;
          o_Z      <= (sum_new == '0);
          o_N      <= is_sub;
          o_H      <= is_sub ? ~h_src : h_src;
          o_C      <= is_sub ? ~csum[CHUNK] : csum[CHUNK];
        end
      end
    end
  end

endmodule

// File: tb/tb_serial_alu.sv
// tb_serial_alu: drives an 8-bit and a 16-bit (HC_BIT=11) instance with the
// same stimulus. Accepted starts push an arithmetic-model prediction into a
// per-instance queue; a negedge monitor pops on o_Done and checks value,
// completion cycle and that outputs hold between completions.
module tb_serial_alu;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  op = '0;
  logic [15:0] a = '0, b = '0;
  logic        cin = 1'b0;

  logic        busy8, done8, z8, n8, h8, c8;
  logic [7:0]  r8;
  logic        busy16, done16, z16, n16, h16, c16;
  logic [15:0] r16;

  serial_alu #(.WIDTH(8), .CHUNK(4), .HC_BIT(3)) u8 (
    .i_Clk(clk), .i_Reset_n(rst_n), .i_Start(start), .i_Op(op),
    .i_A(a[7:0]), .i_B(b[7:0]), .i_Carry(cin),
    .o_Busy(busy8), .o_Done(done8), .o_Result(r8),
    .o_Z(z8), .o_N(n8), .o_H(h8), .o_C(c8));

  serial_alu #(.WIDTH(16), .CHUNK(4), .HC_BIT(11)) u16 (
    .i_Clk(clk), .i_Reset_n(rst_n), .i_Start(start), .i_Op(op),
    .i_A(a), .i_B(b), .i_Carry(cin),
    .o_Busy(busy16), .o_Done(done16), .o_Result(r16),
    .o_Z(z16), .o_N(n16), .o_H(h16), .o_C(c16));

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] res;
    logic        z, n, h, c;
    int          done_at;
  } exp_t;

  exp_t        q [2][$];
  int          cyc = 0;
  int          n_pass = 0, n_tot = 0;
  int          busy_cnt [2] = '{0, 0};
  logic [19:0] prev [2] = '{20'd0, 20'd0};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
  endtask

  // Reference: plain integer arithmetic on the whole operands.
  function automatic exp_t model(input int w, input int hc, input logic [2:0] o,
                                 input logic [15:0] av, input logic [15:0] bv, input logic ci);
    exp_t   e;
    longint m, hm, x, y, k, full, lo;
    logic   sub;
    m   = (longint'(1) << w) - 1;
    hm  = (longint'(1) << (hc + 1)) - 1;
    x   = longint'(av) & m;
    y   = longint'(bv) & m;
    sub = (o == 3'd2) || (o == 3'd3) || (o == 3'd4);
    k   = ((o == 3'd1) || (o == 3'd3)) ? longint'(ci) : 64'sd0;
    if (sub) begin
      full = x - y - k;
      lo   = (x & hm) - (y & hm) - k;
      e.c  = (full < 0);
      e.h  = (lo < 0);
    end else begin
      full = x + y + k;
      lo   = (x & hm) + (y & hm) + k;
      e.c  = (full > m);
      e.h  = (lo > hm);
    end
    e.res     = 16'(full & m);
    e.z       = ((full & m) == 0);
    e.n       = sub;
    if (o == 3'd4) e.res = 16'(x);
    e.done_at = 0;
    return e;
  endfunction

  task automatic mon(input int d, input logic done, input logic busy, input logic [15:0] res,
                     input logic z, input logic n, input logic h, input logic c);
    logic [19:0] cur;
    exp_t        e;
    string       tag;
    tag = (d == 0) ? "w8" : "w16";
    cur = {res, z, n, h, c};
    if (!rst_n) begin
      q[d].delete();
      chk({tag, " reset outputs"}, 32'({busy, done, cur}), 32'd0);
      prev[d] = cur;
      return;
    end
    if (done) begin
      if (q[d].size() == 0) begin
        chk({tag, " unexpected done"}, 32'd1, 32'd0);
      end else begin
        e = q[d].pop_front();
        chk({tag, " done cycle"}, 32'(cyc), 32'(e.done_at));
        chk({tag, " result/ZNHC"}, 32'(cur), 32'({e.res, e.z, e.n, e.h, e.c}));
      end
    end else begin
      chk({tag, " hold"}, 32'(cur), 32'(prev[d]));
      if (q[d].size() > 0 && cyc > q[d][0].done_at) begin
        chk({tag, " missing done"}, 32'd0, 32'd1);
        void'(q[d].pop_front());
      end
    end
    prev[d] = cur;
  endtask

  always @(negedge clk) begin
    mon(0, done8,  busy8,  {8'h00, r8}, z8,  n8,  h8,  c8);
    mon(1, done16, busy16, r16,         z16, n16, h16, c16);
  end

  // Present one cycle of inputs; predict acceptance from the bench's own
  // busy model (busy for NCH edges after an accepted start).
  task automatic step(input logic s, input logic [2:0] o, input logic [15:0] av,
                      input logic [15:0] bv, input logic ci);
    exp_t e;
    int   nch;
    start = s; op = o; a = av; b = bv; cin = ci;
    for (int d = 0; d < 2; d++) begin
      nch = (d == 0) ? 2 : 4;
      if (s && busy_cnt[d] == 0) begin
        e = model((d == 0) ? 8 : 16, (d == 0) ? 3 : 11, o, av, bv, ci);
        e.done_at = cyc + 1 + nch;
        q[d].push_back(e);
        busy_cnt[d] = nch;
      end else if (busy_cnt[d] > 0) begin
        busy_cnt[d]--;
      end
    end
    @(posedge clk); #1;
    chk("w8 busy",  32'(busy8),  32'(busy_cnt[0] > 0));
    chk("w16 busy", 32'(busy16), 32'(busy_cnt[1] > 0));
    start = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 3'd0, 16'h0, 16'h0, 1'b0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Directed cases
    step(1'b1, 3'd0, 16'h003A, 16'h00C6, 1'b0); idle(5);
    step(1'b1, 3'd2, 16'h003E, 16'h000F, 1'b0); idle(5);
    step(1'b1, 3'd3, 16'h0000, 16'h0000, 1'b1); idle(5);
    step(1'b1, 3'd4, 16'h003C, 16'h0040, 1'b0); idle(5);
    step(1'b1, 3'd4, 16'h0042, 16'h0042, 1'b0); idle(5);
    step(1'b1, 3'd0, 16'h0FFF, 16'h0001, 1'b0); idle(5);
    step(1'b1, 3'd1, 16'hFFFF, 16'h0000, 1'b1); idle(5);
    step(1'b1, 3'd7, 16'h8001, 16'h7FFF, 1'b1); idle(5);

    // Start every cycle with changing operands
    for (int i = 0; i < 24; i++)
      step(1'b1, 3'($urandom_range(0, 7)), 16'($urandom), 16'($urandom), 1'($urandom));
    idle(6);

    // Reset one cycle into RUN: outputs clear immediately, no done follows
    step(1'b1, 3'd2, 16'h003E, 16'h000F, 1'b0); idle(5);
    step(1'b1, 3'd0, 16'h1234, 16'h1111, 1'b0);
    step(1'b0, 3'd0, 16'h0, 16'h0, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("w8 async reset",  32'({busy8, done8, r8, z8, n8, h8, c8}), 32'd0);
    chk("w16 async reset", 32'({busy16, done16, r16, z16, n16, h16, c16}), 32'd0);
    busy_cnt[0] = 0;
    busy_cnt[1] = 0;
    @(posedge clk); #1 rst_n = 1'b1;
    idle(6);
    step(1'b1, 3'd0, 16'h3A3A, 16'hC5C6, 1'b0); idle(5);

    // Randomised traffic with frequent (often ignored) start requests
    for (int i = 0; i < 400; i++)
      step(1'($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)),
           16'($urandom), 16'($urandom), 1'($urandom));
    idle(8);

    chk("w8 queue drained",  32'(q[0].size()), 32'd0);
    chk("w16 queue drained", 32'(q[1].size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
